// File: rtl/accelerator_vector_integer_multilane_adder.sv
// Multi-lane vector integer adder/subtractor: one operand beat of LANES elements per COMPUTE cycle.
// Optional saturation on overflow/borrow is enabled by defining ACCELERATOR_VECTOR_ADDER_SATURATION_EN.
module accelerator_vector_integer_multilane_adder #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64,
  parameter int LANES        = 4
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         START,
  output logic                         READY,
  input  logic                         OPERATION,
  input  logic                         DATA_A_IN_ENABLE,
  input  logic                         DATA_B_IN_ENABLE,
  output logic                         DATA_OUT_ENABLE,
  input  logic [DATA_SIZE-1:0]         SIZE_IN,
  input  logic [LANES*DATA_SIZE-1:0]   DATA_A_IN,
  input  logic [LANES*DATA_SIZE-1:0]   DATA_B_IN,
  output logic [LANES*DATA_SIZE-1:0]   DATA_OUT,
  output logic [LANES-1:0]             OVERFLOW_OUT,
  output logic                         OVERFLOW_STICKY_OUT
);

  localparam logic [1:0] STARTER = 2'd0;
  localparam logic [1:0] INPUT   = 2'd1;
  localparam logic [1:0] COMPUTE = 2'd2;

  // Wide enough to compare index+lane against the latched size without wrapping.
  localparam int CW = ((CONTROL_SIZE > DATA_SIZE) ? CONTROL_SIZE : DATA_SIZE) + 1;
  localparam int VW = LANES * DATA_SIZE;

  logic [1:0]              state;
  logic [DATA_SIZE-1:0]    size_reg;
  logic [CONTROL_SIZE-1:0] index;
  logic [VW-1:0]           a_reg;
  logic [VW-1:0]           b_reg;
  logic                    a_flag;
  logic                    b_flag;
  logic                    op_reg;

  logic [VW-1:0]           lane_data;
  logic [LANES-1:0]        lane_ovf;
  logic [DATA_SIZE-1:0]    lane_a;
  logic [DATA_SIZE-1:0]    lane_b;
  logic [DATA_SIZE:0]      lane_sum;
  logic [CW-1:0]           lane_pos;
  logic                    last_beat;

  always_comb begin
    lane_data = '0;
    lane_ovf  = '0;
    lane_a    = '0;
    lane_b    = '0;
    lane_sum  = '0;
    lane_pos  = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_a   = a_reg[l*DATA_SIZE +: DATA_SIZE];
      lane_b   = b_reg[l*DATA_SIZE +: DATA_SIZE];
      lane_pos = CW'(index) + CW'(l);
      if (lane_pos < CW'(size_reg)) begin
        if (op_reg) begin
          // Extended-width difference: top bit is the borrow (A < B).
          lane_sum    = {1'b0, lane_a} - {1'b0, lane_b};
          lane_ovf[l] = lane_sum[DATA_SIZE];
`ifdef ACCELERATOR_VECTOR_ADDER_SATURATION_EN
          if (lane_sum[DATA_SIZE]) lane_sum = '0;
`endif
        end else begin
          lane_sum    = {1'b0, lane_a} + {1'b0, lane_b};
          lane_ovf[l] = lane_sum[DATA_SIZE];
`ifdef ACCELERATOR_VECTOR_ADDER_SATURATION_EN
          if (lane_sum[DATA_SIZE]) lane_sum = '1;
`endif
        end
        lane_data[l*DATA_SIZE +: DATA_SIZE] = lane_sum[DATA_SIZE-1:0];
      end
    end
  end

  assign last_beat = (CW'(index) + CW'(LANES)) >= CW'(size_reg);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state               <= STARTER;
      size_reg            <= '0;
      index               <= '0;
      a_reg               <= '0;
      b_reg               <= '0;
      a_flag              <= 1'b0;
      b_flag              <= 1'b0;
      op_reg              <= 1'b0;
      READY               <= 1'b0;
      DATA_OUT_ENABLE     <= 1'b0;
      DATA_OUT            <= '0;
      OVERFLOW_OUT        <= '0;
      OVERFLOW_STICKY_OUT <= 1'b0;
    end else begin
      READY           <= 1'b0;
      DATA_OUT_ENABLE <= 1'b0;
      case (state)
        STARTER: begin
          if (START) begin
            if (SIZE_IN != '0) begin
              size_reg            <= SIZE_IN;
              index               <= '0;
              OVERFLOW_STICKY_OUT <= 1'b0;
              state               <= INPUT;
            end else begin
              READY <= 1'b1;
            end
          end
        end
        INPUT: begin
          if (DATA_A_IN_ENABLE) begin
            a_reg  <= DATA_A_IN;
            a_flag <= 1'b1;
          end
          if (DATA_B_IN_ENABLE) begin
            b_reg  <= DATA_B_IN;
            b_flag <= 1'b1;
          end
          if ((DATA_A_IN_ENABLE || a_flag) && (DATA_B_IN_ENABLE || b_flag)) begin
            op_reg <= OPERATION;
            state  <= COMPUTE;
          end
        end
        COMPUTE: begin
          DATA_OUT            <= lane_data;
          OVERFLOW_OUT        <= lane_ovf;
          OVERFLOW_STICKY_OUT <= OVERFLOW_STICKY_OUT | (|lane_ovf);
          DATA_OUT_ENABLE     <= 1'b1;
          a_flag              <= 1'b0;
          b_flag              <= 1'b0;
          index               <= index + CONTROL_SIZE'(LANES);
          if (last_beat) begin
            READY <= 1'b1;
            state <= STARTER;
          end else begin
            state <= INPUT;
          end
        end
        default: state <= STARTER;
      endcase
    end
  end

endmodule

// File: tb/tb_accelerator_vector_integer_multilane_adder.sv
// Scoreboard bench for the multi-lane vector adder (DATA_SIZE=8, LANES=4), random plus directed.
module tb_accelerator_vector_integer_multilane_adder;

  localparam int DW = 8;
  localparam int LN = 4;

  logic            CLK = 1'b0;
  logic            RST = 1'b0;
  logic            START = 1'b0;
  logic            READY;
  logic            OPERATION = 1'b0;
  logic            DATA_A_IN_ENABLE = 1'b0;
  logic            DATA_B_IN_ENABLE = 1'b0;
  logic            DATA_OUT_ENABLE;
  logic [DW-1:0]   SIZE_IN = '0;
  logic [LN*DW-1:0] DATA_A_IN = '0;
  logic [LN*DW-1:0] DATA_B_IN = '0;
  logic [LN*DW-1:0] DATA_OUT;
  logic [LN-1:0]   OVERFLOW_OUT;
  logic            OVERFLOW_STICKY_OUT;

  accelerator_vector_integer_multilane_adder #(
    .DATA_SIZE(DW),
    .CONTROL_SIZE(16),
    .LANES(LN)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .START(START),
    .READY(READY),
    .OPERATION(OPERATION),
    .DATA_A_IN_ENABLE(DATA_A_IN_ENABLE),
    .DATA_B_IN_ENABLE(DATA_B_IN_ENABLE),
    .DATA_OUT_ENABLE(DATA_OUT_ENABLE),
    .SIZE_IN(SIZE_IN),
    .DATA_A_IN(DATA_A_IN),
    .DATA_B_IN(DATA_B_IN),
    .DATA_OUT(DATA_OUT),
    .OVERFLOW_OUT(OVERFLOW_OUT),
    .OVERFLOW_STICKY_OUT(OVERFLOW_STICKY_OUT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic             beat;
    logic             rdy;
    logic [LN*DW-1:0] data;
    logic [LN-1:0]    ovf;
    logic             sticky;
    int               cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int va[64];
  int vb[64];
  logic             hold_valid = 1'b0;
  logic [LN*DW-1:0] hold_data = '0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Monitor: every READY / DATA_OUT_ENABLE must match the head of the scoreboard.
  always @(negedge CLK) begin
    if (DATA_OUT_ENABLE || READY) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual enable=%0b ready=%0b required no output (cycle %0d)",
                 DATA_OUT_ENABLE, READY, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("data_out_enable", DATA_OUT_ENABLE, mon_e.beat);
        chk("ready", READY, mon_e.rdy);
        chk("latency_cycle", cyc, mon_e.cyc);
        if (mon_e.beat) begin
          chk("data_out", DATA_OUT, mon_e.data);
          chk("overflow_out", OVERFLOW_OUT, mon_e.ovf);
          chk("overflow_sticky", OVERFLOW_STICKY_OUT, mon_e.sticky);
          hold_data  = mon_e.data;
          hold_valid = 1'b1;
        end
      end
    end else if (hold_valid) begin
      chk("data_out_hold", DATA_OUT, hold_data);
    end
  end

  function automatic logic [LN*DW-1:0] pack(input int base, input logic sel_b);
    logic [LN*DW-1:0] v;
    v = '0;
    for (int l = 0; l < LN; l++) v[l*DW +: DW] = sel_b ? vb[base+l][7:0] : va[base+l][7:0];
    return v;
  endfunction

  // mode 0: random operand order/gaps; mode 1: A, two idle cycles with stray START, then B.
  task automatic send_vector(input int size, input logic op, input int mode, input int abort_beat);
    int beats;
    int c;
    int gap;
    int r;
    logic sticky;
    exp_t e;
    beats  = (size + LN - 1) / LN;
    sticky = 1'b0;
    START     = 1'b1;
    SIZE_IN   = size[DW-1:0];
    OPERATION = ~op;
    c = cyc;
    if (size == 0) begin
      e = '{beat: 1'b0, rdy: 1'b1, data: '0, ovf: '0, sticky: 1'b0, cyc: c + 1};
      sb.push_back(e);
    end
    tick();
    START = 1'b0;
    for (int k = 0; k < beats; k++) begin
      e.beat = 1'b1;
      e.data = '0;
      e.ovf  = '0;
      for (int l = 0; l < LN; l++) begin
        int idx;
        int a;
        int b;
        int res;
        logic o;
        idx = k * LN + l;
        a = va[idx];
        b = vb[idx];
        res = 0;
        o = 1'b0;
        if (idx < size) begin
          if (!op) begin
            o   = (a + b) > 255;
            res = (a + b) % 256;
`ifdef ACCELERATOR_VECTOR_ADDER_SATURATION_EN
            if (o) res = 255;
`endif
          end else begin
            o   = a < b;
            res = (a - b + 256) % 256;
`ifdef ACCELERATOR_VECTOR_ADDER_SATURATION_EN
            if (o) res = 0;
`endif
          end
        end
        e.data[l*DW +: DW] = res[7:0];
        e.ovf[l] = o;
        sticky = sticky | o;
      end
      e.sticky = sticky;
      e.rdy    = (k == beats - 1);
      if (k == abort_beat) begin
        DATA_A_IN = pack(k * LN, 1'b0);
        DATA_A_IN_ENABLE = 1'b1;
        tick();
        DATA_A_IN_ENABLE = 1'b0;
        DATA_B_IN = pack(k * LN, 1'b1);
        DATA_B_IN_ENABLE = 1'b1;
        hold_valid = 1'b0;
        RST = 1'b0;
        tick();
        DATA_B_IN_ENABLE = 1'b0;
        return;
      end
      r = (mode == 1) ? 3 : $urandom_range(0, 2);
      if (r == 0) begin
        DATA_A_IN = pack(k * LN, 1'b0);
        DATA_B_IN = pack(k * LN, 1'b1);
        DATA_A_IN_ENABLE = 1'b1;
        DATA_B_IN_ENABLE = 1'b1;
      end else begin
        if (r == 1 && $urandom_range(0, 1) == 1) begin
          DATA_A_IN = $urandom();
          DATA_A_IN_ENABLE = 1'b1;
          tick();
        end
        if (r == 2) begin
          DATA_B_IN = pack(k * LN, 1'b1);
          DATA_B_IN_ENABLE = 1'b1;
        end else begin
          DATA_A_IN = pack(k * LN, 1'b0);
          DATA_A_IN_ENABLE = 1'b1;
        end
        OPERATION = $urandom_range(0, 1);
        tick();
        DATA_A_IN_ENABLE = 1'b0;
        DATA_B_IN_ENABLE = 1'b0;
        gap = (mode == 1) ? 2 : $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
          START   = (mode == 1 && g == 0) || ($urandom_range(0, 3) == 0);
          SIZE_IN = (mode == 1) ? '0 : DW'($urandom_range(0, 15));
          tick();
          START = 1'b0;
        end
        if (r == 2) begin
          DATA_A_IN = pack(k * LN, 1'b0);
          DATA_A_IN_ENABLE = 1'b1;
        end else begin
          DATA_B_IN = pack(k * LN, 1'b1);
          DATA_B_IN_ENABLE = 1'b1;
        end
      end
      OPERATION = op;
      c = cyc;
      e.cyc = c + 2;
      sb.push_back(e);
      tick();
      DATA_A_IN_ENABLE = 1'b0;
      DATA_B_IN_ENABLE = 1'b0;
      OPERATION = ~op;
      // Stray enable while computing must be ignored.
      if ($urandom_range(0, 1) == 1) begin
        DATA_A_IN = $urandom();
        DATA_A_IN_ENABLE = 1'b1;
      end
      tick();
      DATA_A_IN_ENABLE = 1'b0;
    end
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < 64; i++) begin
      va[i] = ($urandom_range(0, 3) == 0) ? 255 : $urandom_range(0, 255);
      vb[i] = ($urandom_range(0, 3) == 0) ? 255 : $urandom_range(0, 255);
    end
    if (n < 0) fill(0);
  endtask

  task automatic check_zero(input string name);
    @(negedge CLK);
    chk({name, "_ready"}, READY, 0);
    chk({name, "_enable"}, DATA_OUT_ENABLE, 0);
    chk({name, "_data"}, DATA_OUT, 0);
    chk({name, "_ovf"}, OVERFLOW_OUT, 0);
    chk({name, "_sticky"}, OVERFLOW_STICKY_OUT, 0);
  endtask

  initial begin
    RST = 1'b0;
    tick();
    tick();
    check_zero("reset");
    RST = 1'b1;
    tick();

    // Basic add.
    fill(0);
    va[0] = 1; va[1] = 2; va[2] = 3; va[3] = 4;
    vb[0] = 10; vb[1] = 20; vb[2] = 30; vb[3] = 40;
    send_vector(4, 1'b0, 0, -1);
    // Partial last beat: lanes beyond size forced to zero even with 0xFF operands.
    fill(0);
    va[6] = 255; va[7] = 255; vb[6] = 255; vb[7] = 255;
    send_vector(6, 1'b0, 0, -1);
    // Carry-out on lane 0.
    fill(0);
    va[0] = 8'hF0; vb[0] = 8'h20;
    send_vector(4, 1'b0, 0, -1);
    // Borrow on lane 0.
    fill(0);
    va[0] = 5; vb[0] = 7;
    for (int i = 1; i < 4; i++) begin va[i] = 100; vb[i] = 50; end
    send_vector(4, 1'b1, 0, -1);
    // No overflow: sticky must have been cleared by START.
    for (int i = 0; i < 4; i++) begin va[i] = i; vb[i] = i; end
    send_vector(4, 1'b0, 0, -1);
    // Fixed A-then-B timing with START pulsed during INPUT.
    fill(0);
    send_vector(4, 1'b0, 1, -1);
    // Reset during second beat, then immediate restart.
    fill(0);
    send_vector(8, 1'b0, 0, 1);
    check_zero("abort");
    RST = 1'b1;
    fill(0);
    send_vector(5, 1'b1, 0, -1);
    send_vector(0, 1'b0, 0, -1);

    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        DATA_A_IN_ENABLE = 1'b1;
        DATA_B_IN_ENABLE = 1'b1;
        DATA_A_IN = $urandom();
        DATA_B_IN = $urandom();
        tick();
        DATA_A_IN_ENABLE = 1'b0;
        DATA_B_IN_ENABLE = 1'b0;
      end
      fill(0);
      send_vector($urandom_range(0, 14), 1'($urandom_range(0, 1)), 0, -1);
    end

    for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
    chk("scoreboard_drained", sb.size(), 0);
    tick();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/accelerator_vector_integer_multilane_adder.md
ACCELERATOR_VECTOR_INTEGER_MULTILANE_ADDER -- requirements
Module: accelerator_vector_integer_multilane_adder

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 64, element width in bits.
REQ-002 SHALL have parameter CONTROL_SIZE, default 64, width of internal element index counter.
REQ-003 SHALL have parameter LANES, default 4, elements processed per beat (LANES >= 1).
REQ-004 SHALL have port CLK  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port RST  input  1  synchronous active-low reset.
REQ-006 SHALL have port START  input  1  begin vector operation.
REQ-007 SHALL have port READY  output  1  one-cycle pulse, vector complete.
REQ-008 SHALL have port OPERATION  input  1  0 = add, 1 = subtract (A - B).
REQ-009 SHALL have ports DATA_A_IN_ENABLE / DATA_B_IN_ENABLE  input  1 each  operand beat valid.
REQ-010 SHALL have port DATA_OUT_ENABLE  output  1  one-cycle pulse, result beat valid.
REQ-011 SHALL have port SIZE_IN  input  DATA_SIZE  vector length in elements, sampled at START.
REQ-012 SHALL have ports DATA_A_IN / DATA_B_IN  input  LANES*DATA_SIZE each  operand beat, lane l at bits [l*DATA_SIZE +: DATA_SIZE].
REQ-013 SHALL have port DATA_OUT  output  LANES*DATA_SIZE  result beat, same lane packing.
REQ-014 SHALL have port OVERFLOW_OUT  output  LANES  per-lane overflow of current result beat.
REQ-015 SHALL have port OVERFLOW_STICKY_OUT  output  1  OR of all lane overflows since last accepted START.

Function
REQ-016 SHALL implement FSM states STARTER, INPUT, COMPUTE; any other encoding SHALL go to STARTER next cycle.
REQ-017 STARTER: START=1 with SIZE_IN>0 SHALL latch SIZE_IN, clear index, clear OVERFLOW_STICKY_OUT, go INPUT.
REQ-018 STARTER: START=1 with SIZE_IN=0 SHALL pulse READY next cycle, no DATA_OUT_ENABLE, remain STARTER.
REQ-019 START outside STARTER SHALL be ignored; operand enables outside INPUT SHALL be ignored.
REQ-020 INPUT: each enable SHALL capture its operand beat and set its captured flag; repeated enable before the other operand arrives overwrites (last value wins).
REQ-021 INPUT: when both operands are captured or being captured in the same cycle, SHALL latch OPERATION and go COMPUTE next edge.
REQ-022 COMPUTE (one cycle): per lane, unsigned DATA_SIZE arithmetic; add overflow = carry-out, subtract overflow = borrow (A<B).
REQ-023 COMPUTE: lanes with index+l >= latched size SHALL output zero data and zero overflow.
REQ-024 COMPUTE exit edge SHALL register DATA_OUT, OVERFLOW_OUT, OR overflow into sticky, pulse DATA_OUT_ENABLE, clear captured flags, index += LANES.
REQ-025 Latency: DATA_OUT_ENABLE SHALL assert exactly 2 cycles after the edge capturing the second operand.
REQ-026 If index+LANES >= latched size, READY SHALL pulse coincident with final DATA_OUT_ENABLE and FSM returns STARTER; else returns INPUT.
REQ-027 DATA_OUT and OVERFLOW_OUT SHALL hold between beats until next COMPUTE; READY and DATA_OUT_ENABLE high for exactly one cycle each.
REQ-028 Total beats SHALL equal ceil(SIZE/LANES).

Reset
REQ-029 On rising CLK with RST=0: READY, DATA_OUT_ENABLE, DATA_OUT, OVERFLOW_OUT, OVERFLOW_STICKY_OUT = 0; state STARTER; flags, index cleared.
REQ-030 Reset mid-operation SHALL abort without emitting further beats or READY; START accepted the first cycle after RST=1.

Configuration
REQ-031 Macro ACCELERATOR_VECTOR_ADDER_SATURATION_EN defined: overflowing add lanes SHALL output all-ones, underflowing subtract lanes zero; OVERFLOW_OUT still flags them.
REQ-032 Macro undefined: results SHALL wrap modulo 2^DATA_SIZE; saturation logic absent.

Verification (DATA_SIZE=8, LANES=4)
REQ-033 SIZE_IN=4, add, A={1,2,3,4}, B={10,20,30,40} -> one beat DATA_OUT={11,22,33,44}, OVERFLOW_OUT=0, READY with DATA_OUT_ENABLE.
REQ-034 SIZE_IN=6, two beats, lanes 2-3 of beat 2 with A=B=0xFF -> beat 2 lanes 2-3 = 0, overflow 0, READY on beat 2 only.
REQ-035 Add lane 0 0xF0+0x20 -> wrap: 0x10, OVERFLOW_OUT[0]=1, sticky=1; with saturation macro: 0xFF, OVERFLOW_OUT[0]=1.
REQ-036 Subtract 0x05-0x07 -> wrap 0xFE / saturate 0x00, OVERFLOW_OUT=1; next START clears sticky.
REQ-037 A enable cycle 0, B enable cycle 3, START pulsed during INPUT -> DATA_OUT_ENABLE cycle 5, START ignored.
REQ-038 RST=0 during second beat of SIZE_IN=8 -> all outputs 0 next edge, no READY; new START after release completes normally; SIZE_IN=0 START -> READY next cycle only.
